// File: rtl/noc_edge_traffic_port_if.sv
// Router-side link of the edge traffic port: TX flits toward the router, RX flits from it.
// master = the edge port, slave = the router (or a bench standing in for it).
interface noc_edge_traffic_port_if #(
  parameter int FLIT_WIDTH = 16
);
  logic                  clock_tx;
  logic                  tx;
  logic [FLIT_WIDTH-1:0] data_o;
  logic                  credit_i;
  logic                  clock_rx;
  logic                  rx;
  logic [FLIT_WIDTH-1:0] data_i;
  logic                  credit_o;

  modport master (
    output clock_tx, tx, data_o, credit_o,
    input  credit_i, clock_rx, rx, data_i
  );

  modport slave (
    input  clock_tx, tx, data_o, credit_o,
    output credit_i, clock_rx, rx, data_i
  );
endinterface

// File: rtl/noc_edge_traffic_port.sv
// Edge-of-mesh packet source/sink: injects header/length/sequence-payload packets and
// drains incoming packets, counting them and flagging unexpected headers.
module noc_edge_traffic_port #(
  parameter int                    FLIT_WIDTH   = 16,
  parameter logic [FLIT_WIDTH-1:0] SINK_ADDRESS = '0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [FLIT_WIDTH-1:0] i_dest_addr,
  input  logic [FLIT_WIDTH-1:0] i_payload_len,
  output logic                  o_busy,
  input  logic                  i_sink_stall,
  output logic [31:0]           o_pkts_sent,
  output logic [31:0]           o_pkts_recv,
  output logic [31:0]           o_flits_recv,
  output logic                  o_err,
  noc_edge_traffic_port_if.master io_lnk
);

  localparam logic [FLIT_WIDTH-1:0] FLIT_ONE = FLIT_WIDTH'(1);

  typedef enum logic [1:0] {T_IDLE, T_HDR, T_SIZE, T_PAY} tx_state_t;
  typedef enum logic [1:0] {R_HDR, R_SIZE, R_PAY} rx_state_t;

  // ---------------- TX side ----------------
  tx_state_t             r_tx_state, w_tx_state_nxt;
  logic [FLIT_WIDTH-1:0] r_dest, w_dest_nxt;
  logic [FLIT_WIDTH-1:0] r_tx_rem, w_tx_rem_nxt;
  logic [FLIT_WIDTH-1:0] r_seq, w_seq_nxt;
  logic [31:0]           r_pkts_sent, w_pkts_sent_nxt;
  logic                  w_tx;
  logic [FLIT_WIDTH-1:0] w_tx_data;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tx_state  <= T_IDLE;
      r_dest      <= '0;
      r_tx_rem    <= '0;
      r_seq       <= '0;
      r_pkts_sent <= '0;
    end else begin
      r_tx_state  <= w_tx_state_nxt;
      r_dest      <= w_dest_nxt;
      r_tx_rem    <= w_tx_rem_nxt;
      r_seq       <= w_seq_nxt;
      r_pkts_sent <= w_pkts_sent_nxt;
    end
  end

  // r_tx_rem holds N through the size flit, then counts down remaining payload flits
  always_comb begin
    w_tx_state_nxt  = r_tx_state;
    w_dest_nxt      = r_dest;
    w_tx_rem_nxt    = r_tx_rem;
    w_seq_nxt       = r_seq;
    w_pkts_sent_nxt = r_pkts_sent;
    w_tx            = 1'b0;
    w_tx_data       = '0;
    case (r_tx_state)
      T_IDLE: begin
        if (i_start) begin
          w_dest_nxt     = i_dest_addr;
          w_tx_rem_nxt   = i_payload_len;
          w_tx_state_nxt = T_HDR;
        end
      end
      T_HDR: begin
        w_tx      = 1'b1;
        w_tx_data = r_dest;
        if (io_lnk.credit_i) w_tx_state_nxt = T_SIZE;
      end
      T_SIZE: begin
        w_tx      = 1'b1;
        w_tx_data = r_tx_rem;
        if (io_lnk.credit_i) begin
          if (r_tx_rem != '0) begin
            w_tx_state_nxt = T_PAY;
          end else begin
            w_tx_state_nxt  = T_IDLE;
            w_pkts_sent_nxt = r_pkts_sent + 32'd1;
          end
        end
      end
      T_PAY: begin
        w_tx      = 1'b1;
        w_tx_data = r_seq;
        if (io_lnk.credit_i) begin
          w_seq_nxt    = r_seq + FLIT_ONE;
          w_tx_rem_nxt = r_tx_rem - FLIT_ONE;
          if (r_tx_rem == FLIT_ONE) begin
            w_tx_state_nxt  = T_IDLE;
            w_pkts_sent_nxt = r_pkts_sent + 32'd1;
          end
        end
      end
      default: w_tx_state_nxt = T_IDLE;
    endcase
  end

  assign io_lnk.clock_tx = i_clock;
  assign io_lnk.tx       = w_tx;
  assign io_lnk.data_o   = w_tx_data;
  assign o_busy          = (r_tx_state != T_IDLE);
  assign o_pkts_sent     = r_pkts_sent;

  // ---------------- RX side ----------------
  rx_state_t             r_rx_state, w_rx_state_nxt;
  logic [FLIT_WIDTH-1:0] r_rx_rem, w_rx_rem_nxt;
  logic [31:0]           r_pkts_recv, w_pkts_recv_nxt;
  logic [31:0]           r_flits_recv, w_flits_recv_nxt;
  logic                  r_err, w_err_nxt;
  logic                  w_credit;
  logic                  w_rx_acc;
  logic                  w_unused_clock_rx;

  assign w_unused_clock_rx = io_lnk.clock_rx;
  assign w_credit          = !i_sink_stall && !i_reset;
  assign w_rx_acc          = io_lnk.rx && w_credit;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rx_state   <= R_HDR;
      r_rx_rem     <= '0;
      r_pkts_recv  <= '0;
      r_flits_recv <= '0;
      r_err        <= 1'b0;
    end else begin
      r_rx_state   <= w_rx_state_nxt;
      r_rx_rem     <= w_rx_rem_nxt;
      r_pkts_recv  <= w_pkts_recv_nxt;
      r_flits_recv <= w_flits_recv_nxt;
      r_err        <= w_err_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt   = r_rx_state;
    w_rx_rem_nxt     = r_rx_rem;
    w_pkts_recv_nxt  = r_pkts_recv;
    w_flits_recv_nxt = r_flits_recv;
    w_err_nxt        = r_err;
    if (w_rx_acc) begin
      w_flits_recv_nxt = r_flits_recv + 32'd1;
      case (r_rx_state)
        R_HDR: begin
          if (io_lnk.data_i != SINK_ADDRESS) w_err_nxt = 1'b1;
          w_rx_state_nxt = R_SIZE;
        end
        R_SIZE: begin
          if (io_lnk.data_i != '0) begin
            w_rx_rem_nxt   = io_lnk.data_i;
            w_rx_state_nxt = R_PAY;
          end else begin
            w_pkts_recv_nxt = r_pkts_recv + 32'd1;
            w_rx_state_nxt  = R_HDR;
          end
        end
        R_PAY: begin
          w_rx_rem_nxt = r_rx_rem - FLIT_ONE;
          if (r_rx_rem == FLIT_ONE) begin
            w_pkts_recv_nxt = r_pkts_recv + 32'd1;
            w_rx_state_nxt  = R_HDR;
          end
        end
        default: w_rx_state_nxt = R_HDR;
      endcase
    end
  end

  assign io_lnk.credit_o = w_credit;
  assign o_pkts_recv     = r_pkts_recv;
  assign o_flits_recv    = r_flits_recv;
  assign o_err           = r_err;

endmodule

// File: tb/tb_noc_edge_traffic_port.sv
// Bench for noc_edge_traffic_port: cycle vector table, directed RX/reset/wrap sequences,
// and randomized traffic against a queue-based packet model.
module tb_noc_edge_traffic_port;
  localparam int FW = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dest;
  logic [15:0] len;
  logic        busy;
  logic        stall;
  logic [31:0] sent;
  logic [31:0] recv;
  logic [31:0] frecv;
  logic        err;

  int checks   = 0;
  int failures = 0;

  noc_edge_traffic_port_if #(.FLIT_WIDTH(FW)) lnk ();

  noc_edge_traffic_port #(.FLIT_WIDTH(FW), .SINK_ADDRESS(16'h0000)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_start       (start),
    .i_dest_addr   (dest),
    .i_payload_len (len),
    .o_busy        (busy),
    .i_sink_stall  (stall),
    .o_pkts_sent   (sent),
    .o_pkts_recv   (recv),
    .o_flits_recv  (frecv),
    .o_err         (err),
    .io_lnk        (lnk)
  );

  always #5 clk = ~clk;
  assign lnk.clock_rx = clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 50) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (packet queues) ----------------
  typedef struct {
    logic [15:0] d;
    bit          last;
    bit          hdr;
  } fl_t;

  fl_t         txq[$];
  fl_t         rxq[$];
  bit          mon_en = 1'b0;
  logic [15:0] m_seq;
  int unsigned m_sent, m_recv, m_flits;
  bit          m_err;

  function automatic void push_rx(input logic [15:0] h, input int unsigned n);
    fl_t f;
    f.d = h; f.hdr = 1'b1; f.last = 1'b0;
    rxq.push_back(f);
    f.d = 16'(n); f.hdr = 1'b0; f.last = (n == 0);
    rxq.push_back(f);
    for (int unsigned i = 0; i < n; i++) begin
      f.d = 16'($urandom); f.last = (i == n - 1);
      rxq.push_back(f);
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        chk("mon.credit_in_reset", lnk.credit_o, 0);
        txq.delete(); rxq.delete();
        m_seq = '0; m_sent = 0; m_recv = 0; m_flits = 0; m_err = 1'b0;
      end else begin
        automatic bit idle = (txq.size() == 0);
        chk("mon.busy", busy, !idle);
        chk("mon.tx", lnk.tx, !idle);
        chk("mon.data_o", lnk.data_o, idle ? 32'h0 : 32'(txq[0].d));
        chk("mon.pkts_sent", sent, m_sent);
        chk("mon.pkts_recv", recv, m_recv);
        chk("mon.flits_recv", frecv, m_flits);
        chk("mon.err", err, m_err);
        chk("mon.credit_o", lnk.credit_o, !stall);
        if (!idle && lnk.credit_i) begin
          if (txq[0].last) m_sent++;
          void'(txq.pop_front());
        end
        if (idle && start) begin
          fl_t f;
          f.hdr = 1'b0;
          f.d = dest; f.last = 1'b0; txq.push_back(f);
          f.d = len;  f.last = (len == 0); txq.push_back(f);
          for (int unsigned i = 0; i < 32'(len); i++) begin
            f.d = m_seq + 16'(i); f.last = (i == 32'(len) - 1);
            txq.push_back(f);
          end
          m_seq = m_seq + len;
        end
        if (lnk.rx && !stall && rxq.size() > 0) begin
          m_flits++;
          if (rxq[0].hdr && rxq[0].d != 16'h0000) m_err = 1'b1;
          if (rxq[0].last) m_recv++;
          void'(rxq.pop_front());
        end
      end
    end
  end

  // ---------------- cycle vector table ----------------
  typedef struct {
    logic        s;
    logic [15:0] d;
    logic [15:0] l;
    logic        cr;
    logic        etx;
    logic [15:0] edata;
    logic        ebusy;
    logic [31:0] esent;
  } vec_t;

  function automatic vec_t mk(logic s, logic [15:0] d, logic [15:0] l, logic cr,
                              logic etx, logic [15:0] ed, logic eb, logic [31:0] es);
    vec_t v;
    v.s = s; v.d = d; v.l = l; v.cr = cr;
    v.etx = etx; v.edata = ed; v.ebusy = eb; v.esent = es;
    return v;
  endfunction

  vec_t        vt[26];
  logic [15:0] rx4[4];
  logic [15:0] rx5[12];
  logic [15:0] tx5[4];
  logic [15:0] w6[5];
  int          idx;
  int          n;

  initial begin
    vt[0]  = mk(1, 16'h0011, 16'd3, 1, 0, 16'h0000, 0, 0);
    vt[1]  = mk(0, 16'h0000, 16'd0, 1, 1, 16'h0011, 1, 0);
    vt[2]  = mk(0, 16'h0000, 16'd0, 1, 1, 16'h0003, 1, 0);
    vt[3]  = mk(0, 16'h0000, 16'd0, 1, 1, 16'h0000, 1, 0);
    vt[4]  = mk(0, 16'h0000, 16'd0, 1, 1, 16'h0001, 1, 0);
    vt[5]  = mk(0, 16'h0000, 16'd0, 1, 1, 16'h0002, 1, 0);
    vt[6]  = mk(0, 16'h0000, 16'd0, 1, 0, 16'h0000, 0, 1);
    vt[7]  = mk(1, 16'h0011, 16'd3, 1, 0, 16'h0000, 0, 1);
    vt[8]  = mk(0, 16'h0000, 16'd0, 1, 1, 16'h0011, 1, 1);
    vt[9]  = mk(0, 16'h0000, 16'd0, 0, 1, 16'h0003, 1, 1);
    vt[10] = mk(0, 16'h0000, 16'd0, 0, 1, 16'h0003, 1, 1);
    vt[11] = mk(0, 16'h0000, 16'd0, 0, 1, 16'h0003, 1, 1);
    vt[12] = mk(0, 16'h0000, 16'd0, 0, 1, 16'h0003, 1, 1);
    vt[13] = mk(0, 16'h0000, 16'd0, 1, 1, 16'h0003, 1, 1);
    vt[14] = mk(0, 16'h0000, 16'd0, 1, 1, 16'h0003, 1, 1);
    vt[15] = mk(0, 16'h0000, 16'd0, 1, 1, 16'h0004, 1, 1);
    vt[16] = mk(0, 16'h0000, 16'd0, 1, 1, 16'h0005, 1, 1);
    vt[17] = mk(0, 16'h0000, 16'd0, 1, 0, 16'h0000, 0, 2);
    vt[18] = mk(1, 16'h0011, 16'd0, 1, 0, 16'h0000, 0, 2);
    vt[19] = mk(0, 16'h0000, 16'd0, 1, 1, 16'h0011, 1, 2);
    vt[20] = mk(1, 16'h00FF, 16'd1, 1, 1, 16'h0000, 1, 2);
    vt[21] = mk(1, 16'h0011, 16'd1, 1, 0, 16'h0000, 0, 3);
    vt[22] = mk(0, 16'h0000, 16'd0, 1, 1, 16'h0011, 1, 3);
    vt[23] = mk(0, 16'h0000, 16'd0, 1, 1, 16'h0001, 1, 3);
    vt[24] = mk(0, 16'h0000, 16'd0, 1, 1, 16'h0006, 1, 3);
    vt[25] = mk(0, 16'h0000, 16'd0, 1, 0, 16'h0000, 0, 4);

    rx4 = '{16'h0000, 16'h0002, 16'hAAAA, 16'hBBBB};
    rx5 = '{16'h0000, 16'h0003, 16'hAAAA, 16'h0000, 16'h0000, 16'h0000,
            16'h0000, 16'h0001, 16'hCCCC, 16'h0000, 16'h0000, 16'h0000};
    tx5 = '{16'h0011, 16'h0002, 16'h0000, 16'h0001};
    w6  = '{16'h0011, 16'h0003, 16'hFFFE, 16'hFFFF, 16'h0000};

    // reset state
    rst = 1'b1; start = 1'b0; dest = '0; len = '0; stall = 1'b0;
    lnk.credit_i = 1'b0; lnk.rx = 1'b0; lnk.data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst.tx", lnk.tx, 0);
    chk("rst.data_o", lnk.data_o, 0);
    chk("rst.busy", busy, 0);
    chk("rst.credit_o", lnk.credit_o, 0);
    chk("rst.pkts_sent", sent, 0);
    chk("rst.pkts_recv", recv, 0);
    chk("rst.flits_recv", frecv, 0);
    chk("rst.err", err, 0);
    chk("rst.clock_tx", lnk.clock_tx, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // TX cycle table: streaming, credit stall on size flit, N=0 and ignored start
    for (int i = 0; i < 26; i++) begin
      start = vt[i].s; dest = vt[i].d; len = vt[i].l; lnk.credit_i = vt[i].cr;
      @(negedge clk);
      chk($sformatf("vec%0d.tx", i), lnk.tx, vt[i].etx);
      chk($sformatf("vec%0d.data_o", i), lnk.data_o, vt[i].edata);
      chk($sformatf("vec%0d.busy", i), busy, vt[i].ebusy);
      chk($sformatf("vec%0d.pkts_sent", i), sent, vt[i].esent);
      @(posedge clk); #1;
    end
    start = 1'b0; lnk.credit_i = 1'b1;

    // RX with sink_stall toggling every cycle
    idx = 0;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      stall = c[0];
      lnk.rx = 1'b1; lnk.data_i = rx4[idx];
      @(negedge clk);
      chk("rx4.credit_o", lnk.credit_o, !stall);
      if (!stall) idx++;
      @(posedge clk); #1;
    end
    chk("rx4.all_sent", idx, 4);
    lnk.rx = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk("rx4.pkts_recv", recv, 1);
    chk("rx4.flits_recv", frecv, 4);
    chk("rx4.err", err, 0);
    @(posedge clk); #1;
    lnk.rx = 1'b1; lnk.data_i = 16'h0005;
    @(posedge clk); #1;
    lnk.data_i = 16'h0000;
    @(posedge clk); #1;
    lnk.rx = 1'b0;
    @(negedge clk);
    chk("rx4.err_set", err, 1);
    chk("rx4.pkts_recv2", recv, 2);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rx4.err_sticky", err, 1);
    @(posedge clk); #1;

    // reset mid-payload on both sides, then clean restart
    for (int c = 0; c < 12; c++) begin
      start = (c == 0 || c == 6); dest = 16'h0011; len = (c == 0) ? 16'd5 : 16'd2;
      rst = (c == 4 || c == 5);
      lnk.rx = (c < 3) || (c >= 6 && c < 9);
      lnk.data_i = rx5[c];
      @(negedge clk);
      if (c == 3) chk("rst5.pre_reset_seq", lnk.data_o, 16'h0007);
      if (c == 4) chk("rst5.credit_o", lnk.credit_o, 0);
      if (c == 5) begin
        chk("rst5.tx", lnk.tx, 0);
        chk("rst5.data_o", lnk.data_o, 0);
        chk("rst5.busy", busy, 0);
        chk("rst5.credit_o2", lnk.credit_o, 0);
        chk("rst5.pkts_sent", sent, 0);
        chk("rst5.pkts_recv", recv, 0);
        chk("rst5.flits_recv", frecv, 0);
        chk("rst5.err", err, 0);
      end
      if (c >= 7 && c <= 10) begin
        chk($sformatf("rst5.flit%0d.tx", c - 7), lnk.tx, 1);
        chk($sformatf("rst5.flit%0d.data", c - 7), lnk.data_o, tx5[c - 7]);
      end
      @(posedge clk); #1;
    end
    start = 1'b0; rst = 1'b0; lnk.rx = 1'b0;
    @(negedge clk);
    chk("rst5.pkts_sent_after", sent, 1);
    chk("rst5.pkts_recv_after", recv, 1);
    chk("rst5.flits_recv_after", frecv, 3);
    chk("rst5.err_after", err, 0);
    chk("rst5.busy_after", busy, 0);
    @(posedge clk); #1;

    // randomized traffic against the queue model, with one reset mid-run
    mon_en = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst   = (c == 1500);
      start = ($urandom_range(0, 3) == 0);
      dest  = 16'($urandom);
      len   = 16'($urandom_range(0, 4));
      lnk.credit_i = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 2) == 0);
      if (rxq.size() < 4)
        push_rx(($urandom_range(0, 7) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000,
                $urandom_range(0, 3));
      lnk.rx = ($urandom_range(0, 3) != 0) && (rxq.size() > 0);
      lnk.data_i = lnk.rx ? rxq[0].d : 16'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b0; start = 1'b0; lnk.credit_i = 1'b1; stall = 1'b0;
    for (int c = 0; c < 200 && (txq.size() > 0 || rxq.size() > 0); c++) begin
      lnk.rx = (rxq.size() > 0);
      lnk.data_i = lnk.rx ? rxq[0].d : 16'h0000;
      @(posedge clk); #1;
    end
    lnk.rx = 1'b0;
    chk("rand.drained", 32'(txq.size() + rxq.size()), 0);

    // sequence-counter wrap: 65534 payload flits, then N=3
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b1; dest = 16'h0011; len = 16'hFFFE;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 70000);
    chk("wrap.long_pkt_done", busy, 0);
    @(posedge clk); #1;
    start = 1'b1; len = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("wrap.flit%0d", k), lnk.data_o, w6[k]);
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("wrap.pkts_sent", sent, 2);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
